laser_line_gen: RTL and testbench

//  Source side of the camera pixel interface (fvh/dv/px). Synthesises binary "laser line" frames:
//  one white run per active row at a programmable, per-row sloped position, rest black. Drives the

---
 rtl/linegen_pkg.sv | 29 ++
 rtl/linegen_lfsr.sv | 32 +++
 rtl/laser_line_gen.sv | 236 +++++++++++++++++++++++
 tb/tb_laser_line_gen.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/linegen_pkg.sv
// Shared types and constants for the laser-line frame generator.
// State encoding, fvh codes and pixel levels used by the generator and its bench.
package linegen_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VBLANK = 3'd1,
        HBLANK = 3'd2,
        ACTIVE = 3'd3,
        TRAIL  = 3'd4
    } state_e;

    // fvh = {field, vblank, hblank}
    localparam logic [2:0] FVH_IDLE   = 3'b000;
    localparam logic [2:0] FVH_VBLANK = 3'b010;
    localparam logic [2:0] FVH_HBLANK = 3'b001;
    localparam logic [2:0] FVH_ACTIVE = 3'b000;

    localparam logic [7:0] PX_WHITE = 8'hFF;
    localparam logic [7:0] PX_BLACK = 8'h00;

    // ceil((s+e)/2) through a 12-bit intermediate sum
    function automatic logic [10:0] ceil_mid(input logic [11:0] s, input logic [11:0] e);
        logic [11:0] sum;
        sum = s + e + 12'd1;
        return sum[11:1];
    endfunction

endpackage

// File: rtl/linegen_lfsr.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), advances when en is high.
// Latency: new value one clock after an enabled cycle; no backpressure.
module linegen_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/laser_line_gen.sv
// Camera-side pixel source: synthetic frames with one sloped white run per row plus expected midpoints.
// Latency: every output is registered, one clock behind the state/counters; free-running, no backpressure.
// LINEGEN_NOISE_EN adds LFSR-driven single-pixel holes inside each run.
module laser_line_gen
    import linegen_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 16,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic [10:0] cfg_start,
    input  logic [10:0] cfg_width,
    input  logic [3:0]  cfg_slope,
    output logic [2:0]  fvh_out,
    output logic        dv_out,
    output logic [7:0]  px_out,
    output logic [10:0] exp_row,
    output logic [10:0] exp_midpoint,
    output logic        exp_valid,
    output logic        frame_done
);

    localparam logic [15:0] V_LAST    = 16'(V_BLANK - 1);
    localparam logic [15:0] H_LAST    = 16'(H_BLANK - 1);
    localparam logic [15:0] A_LAST    = 16'(H_ACTIVE - 1);
    localparam logic [10:0] ROW_LAST  = 11'(V_ACTIVE - 1);
    localparam logic [11:0] COL_MAX   = 12'(H_ACTIVE - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [10:0] row_q, row_d;
    logic [12:0] acc_q, acc_d;
    logic [10:0] width_q, width_d;
    logic [3:0]  slope_q, slope_d;
    logic        fd_pend_q, fd_pend_d;

    logic [2:0]  fvh_q, fvh_d;
    logic        dv_q, dv_d;
    logic [7:0]  px_q, px_d;
    logic [10:0] exp_row_q, exp_row_d;
    logic [10:0] exp_mid_q, exp_mid_d;
    logic        exp_vld_q, exp_vld_d;
    logic        frame_done_q;

    logic [13:0] acc_sum;
    logic [12:0] acc_step;
    logic [11:0] s_col, e_sum, e_col, col;
    logic        in_run, hole;

    // Accumulator saturates at its signed 13-bit limits instead of wrapping.
    always_comb begin
        acc_sum = {acc_q[12], acc_q} + {{10{slope_q[3]}}, slope_q};
        if (acc_sum[13] != acc_sum[12]) begin
            acc_step = acc_sum[13] ? 13'h1000 : 13'h0FFF;
        end else begin
            acc_step = acc_sum[12:0];
        end
    end

    always_comb begin
        if (acc_q[12]) begin
            s_col = 12'd0;
        end else if (acc_q[11:0] > COL_MAX) begin
            s_col = COL_MAX;
        end else begin
            s_col = acc_q[11:0];
        end
        e_sum = s_col + {1'b0, width_q} - 12'd1;
        e_col = (e_sum > COL_MAX) ? COL_MAX : e_sum;
    end

    assign col    = cnt_q[11:0];
    assign in_run = (state_q == ACTIVE) && (width_q != 11'd0) && (col >= s_col) && (col <= e_col);

`ifdef LINEGEN_NOISE_EN
    logic [15:0] lfsr_w;
    logic        lfsr_unused;
    logic        hole_prev_q;

    linegen_lfsr #(.SEED(16'hACE1)) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (state_q == ACTIVE),
        .lfsr_o  (lfsr_w)
    );

    assign lfsr_unused = ^lfsr_w[15:4];
    assign hole = in_run && (col > s_col) && (col < e_col) && (lfsr_w[3:0] == 4'd0) && !hole_prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hole_prev_q <= 1'b0;
        end else begin
            hole_prev_q <= hole;
        end
    end
`else
    assign hole = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 16'd1;
        row_d     = row_q;
        acc_d     = acc_q;
        width_d   = width_q;
        slope_d   = slope_q;
        fd_pend_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                if (run) begin
                    state_d = VBLANK;
                    row_d   = 11'd0;
                    acc_d   = {2'b00, cfg_start};
                    width_d = cfg_width;
                    slope_d = cfg_slope;
                end
            end
            VBLANK: begin
                if (cnt_q == V_LAST) begin
                    state_d = HBLANK;
                    cnt_d   = 16'd0;
                end
            end
            HBLANK: begin
                if (cnt_q == H_LAST) begin
                    state_d = ACTIVE;
                    cnt_d   = 16'd0;
                end
            end
            ACTIVE: begin
                if (cnt_q == A_LAST) begin
                    cnt_d = 16'd0;
                    if (row_q == ROW_LAST) begin
                        state_d = TRAIL;
                    end else begin
                        state_d = HBLANK;
                        row_d   = row_q + 11'd1;
                        acc_d   = acc_step;
                    end
                end
            end
            TRAIL: begin
                if (cnt_q == H_LAST) begin
                    cnt_d     = 16'd0;
                    fd_pend_d = 1'b1;
                    if (run) begin
                        state_d = VBLANK;
                        row_d   = 11'd0;
                        acc_d   = {2'b00, cfg_start};
                        width_d = cfg_width;
                        slope_d = cfg_slope;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    always_comb begin
        fvh_d     = FVH_IDLE;
        dv_d      = 1'b0;
        px_d      = PX_BLACK;
        exp_vld_d = 1'b0;
        exp_row_d = exp_row_q;
        exp_mid_d = exp_mid_q;
        case (state_q)
            VBLANK:        fvh_d = FVH_VBLANK;
            HBLANK, TRAIL: fvh_d = FVH_HBLANK;
            ACTIVE: begin
                fvh_d = FVH_ACTIVE;
                dv_d  = 1'b1;
                px_d  = (in_run && !hole) ? PX_WHITE : PX_BLACK;
                if (cnt_q == 16'd0 && width_q != 11'd0) begin
                    exp_vld_d = 1'b1;
                    exp_row_d = row_q;
                    exp_mid_d = ceil_mid(s_col, e_col);
                end
            end
            default: fvh_d = FVH_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= 16'd0;
            row_q        <= 11'd0;
            acc_q        <= 13'd0;
            width_q      <= 11'd0;
            slope_q      <= 4'd0;
            fd_pend_q    <= 1'b0;
            fvh_q        <= 3'b000;
            dv_q         <= 1'b0;
            px_q         <= 8'h00;
            exp_row_q    <= 11'd0;
            exp_mid_q    <= 11'd0;
            exp_vld_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            acc_q        <= acc_d;
            width_q      <= width_d;
            slope_q      <= slope_d;
            fd_pend_q    <= fd_pend_d;
            fvh_q        <= fvh_d;
            dv_q         <= dv_d;
            px_q         <= px_d;
            exp_row_q    <= exp_row_d;
            exp_mid_q    <= exp_mid_d;
            exp_vld_q    <= exp_vld_d;
            frame_done_q <= fd_pend_q;
        end
    end

    assign fvh_out      = fvh_q;
    assign dv_out       = dv_q;
    assign px_out       = px_q;
    assign exp_row      = exp_row_q;
    assign exp_midpoint = exp_mid_q;
    assign exp_valid    = exp_vld_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_laser_line_gen.sv
// Directed bench for laser_line_gen on a 16x4 frame with hand-computed run geometry and midpoints.
`timescale 1ns/1ps
module tb_laser_line_gen;

    localparam int HA = 16;
    localparam int HB = 4;
    localparam int VA = 4;
    localparam int VB = 4;

    typedef int row4_t[4];

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic [10:0] cfg_start = '0;
    logic [10:0] cfg_width = '0;
    logic [3:0]  cfg_slope = '0;
    logic [2:0]  fvh_out;
    logic        dv_out;
    logic [7:0]  px_out;
    logic [10:0] exp_row;
    logic [10:0] exp_midpoint;
    logic        exp_valid;
    logic        frame_done;

    laser_line_gen #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .run          (run),
        .cfg_start    (cfg_start),
        .cfg_width    (cfg_width),
        .cfg_slope    (cfg_slope),
        .fvh_out      (fvh_out),
        .dv_out       (dv_out),
        .px_out       (px_out),
        .exp_row      (exp_row),
        .exp_midpoint (exp_midpoint),
        .exp_valid    (exp_valid),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Frame monitor, sampled on the falling edge.
    logic [2:0]  prev_fvh = 3'b000;
    logic        prev_dv = 1'b0;
    int          line_idx = -1;
    int          col = 0;
    int          hb_rise = 0;
    int          vb_rise_tot = 0;
    int          exp_cnt = 0;
    int          exp_pos_bad = 0;
    int          bad_px = 0;
    int          fd_ok = 0;
    int          activity = 0;
    logic [15:0] mask [VA];
    int          exp_mid_a [VA];
    int          exp_row_seq [8];

    always @(negedge clk) begin
        if (fvh_out[1] && !prev_fvh[1]) begin
            vb_rise_tot++;
            hb_rise     = 0;
            exp_cnt     = 0;
            exp_pos_bad = 0;
            bad_px      = 0;
            line_idx    = -1;
            for (int i = 0; i < VA; i++) begin
                mask[i]      = '0;
                exp_mid_a[i] = -1;
            end
        end
        if (fvh_out[0] && !prev_fvh[0]) hb_rise++;
        if (dv_out && !prev_dv) begin
            line_idx++;
            col = 0;
        end else if (dv_out) begin
            col++;
        end
        if (dv_out && line_idx >= 0 && line_idx < VA && col < HA && px_out == 8'hFF)
            mask[line_idx][col] = 1'b1;
        if (!dv_out && px_out != 8'h00) bad_px++;
        if (dv_out && px_out != 8'hFF && px_out != 8'h00) bad_px++;
        if (exp_valid) begin
            if (exp_cnt < 8) exp_row_seq[exp_cnt] = int'(exp_row);
            if (exp_row < VA) exp_mid_a[exp_row] = int'(exp_midpoint);
            if (!(dv_out && col == 0)) exp_pos_bad++;
            exp_cnt++;
        end
        if (frame_done && prev_fvh == 3'b001 && fvh_out != 3'b001) fd_ok++;
        if (fvh_out != 3'b000 || dv_out || px_out != 8'h00 || exp_valid || frame_done) activity++;
        prev_fvh = fvh_out;
        prev_dv  = dv_out;
    end

    row4_t want_s, want_e, want_m;
    int    want_w;

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!frame_done && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, (n < 400) ? 1 : 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic one_frame(input string tag, input int start, input int width, input int slope);
        int fd0;
        @(negedge clk);
        fd0       = fd_ok;
        cfg_start = 11'(start);
        cfg_width = 11'(width);
        cfg_slope = 4'(slope);
        run       = 1'b1;
        repeat (3) @(negedge clk);
        run = 1'b0;
        wait_done(tag);
        chk({tag, "_fd_after_hblank"}, fd_ok - fd0, 1);
    endtask

    task automatic check_rows(input string tag);
        logic [15:0] want, miss;
        for (int r = 0; r < VA; r++) begin
            want = '0;
            if (want_w != 0)
                for (int c = want_s[r]; c <= want_e[r]; c++) want[c] = 1'b1;
`ifdef LINEGEN_NOISE_EN
            miss = want & ~mask[r];
            chk($sformatf("%s_row%0d_extra", tag, r), int'(mask[r] & ~want), 0);
            chk($sformatf("%s_row%0d_edge_hole", tag, r), (want_w != 0) ? int'(miss[want_s[r]] | miss[want_e[r]]) : 0, 0);
            chk($sformatf("%s_row%0d_adj_hole", tag, r), int'(miss & (miss >> 1)), 0);
`else
            miss = '0;
            chk($sformatf("%s_row%0d_mask", tag, r), int'(mask[r]), int'(want));
`endif
            if (want_w != 0) begin
                chk($sformatf("%s_row%0d_mid", tag, r), exp_mid_a[r], want_m[r]);
                chk($sformatf("%s_seq%0d_row", tag, r), exp_row_seq[r], r);
            end
        end
        chk({tag, "_exp_cnt"}, exp_cnt, (want_w != 0) ? VA : 0);
        chk({tag, "_exp_pos"}, exp_pos_bad, 0);
        chk({tag, "_hb_rises"}, hb_rise, VA + 1);
        chk({tag, "_blank_px"}, bad_px, 0);
    endtask

    // Midpoint a downstream skeletonizer would derive from the observed pixels.
    task automatic skel_cross(input string tag);
        int f, l;
        for (int r = 0; r < VA; r++) begin
            f = -1;
            l = -1;
            for (int c = 0; c < HA; c++) begin
                if (mask[r][c]) begin
                    if (f < 0) f = c;
                    l = c;
                end
            end
            chk($sformatf("%s_row%0d_skel", tag, r), exp_mid_a[r], (f + l + 1) / 2);
        end
    endtask

    initial begin
        int act0, vb0, n;

        // 1: reset and idle
        repeat (3) @(negedge clk);
        chk("rst_fvh_dv_px", int'({fvh_out, dv_out, px_out}), 0);
        chk("rst_exp", int'({exp_row, exp_midpoint, exp_valid, frame_done}), 0);
        reset_n = 1'b1;
        @(negedge clk);
        #1 act0 = activity;
        repeat (50) @(negedge clk);
        #1 chk("idle_quiet", activity - act0, 0);
        chk("idle_no_frame", vb_rise_tot, 0);

        // 2: flat run
        vb0 = vb_rise_tot;
        one_frame("flat", 5, 4, 0);
        want_w = 4; want_s = '{5, 5, 5, 5}; want_e = '{8, 8, 8, 8}; want_m = '{7, 7, 7, 7};
        check_rows("flat");
        chk("flat_one_frame", vb_rise_tot - vb0, 1);

        // 3: positive slope, negative slope with right-edge clip
        one_frame("up", 2, 3, 3);
        want_w = 3; want_s = '{2, 5, 8, 11}; want_e = '{4, 7, 10, 13}; want_m = '{3, 6, 9, 12};
        check_rows("up");
        one_frame("clip", 14, 6, -1);
        want_w = 6; want_s = '{14, 13, 12, 11}; want_e = '{15, 15, 15, 15}; want_m = '{15, 14, 14, 13};
        check_rows("clip");

        // 4: cfg change and run drop during row 1
        vb0       = vb_rise_tot;
        cfg_start = 11'd5;
        cfg_width = 11'd4;
        cfg_slope = 4'd0;
        run       = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            #1 n++;
        end while (!(line_idx == 1 && dv_out) && n < 200);
        chk("mid_row1_reached", (n < 200) ? 1 : 0, 1);
        cfg_start = 11'd10;
        cfg_slope = 4'd3;
        cfg_width = 11'd2;
        run       = 1'b0;
        wait_done("mid");
        want_w = 4; want_s = '{5, 5, 5, 5}; want_e = '{8, 8, 8, 8}; want_m = '{7, 7, 7, 7};
        check_rows("mid");
        repeat (40) @(negedge clk);
        #1 chk("mid_then_idle", vb_rise_tot - vb0, 1);
        chk("mid_idle_fvh", int'(fvh_out), 0);

        // 4b: reset during an active line
        @(negedge clk);
        cfg_start = 11'd5;
        cfg_width = 11'd4;
        cfg_slope = 4'd0;
        run       = 1'b1;
        n = 0;
        while (!dv_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("arst_in_active", int'(dv_out), 1);
        run     = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("arst_fvh_dv_px", int'({fvh_out, dv_out, px_out}), 0);
        chk("arst_exp", int'({exp_row, exp_midpoint, exp_valid, frame_done}), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1 act0 = activity;
        repeat (20) @(negedge clk);
        #1 chk("arst_then_idle", activity - act0, 0);

        // 5: empty run, then skeletonizer cross-check on a clean frame
        one_frame("blank", 5, 0, 0);
        want_w = 0; want_s = '{0, 0, 0, 0}; want_e = '{0, 0, 0, 0}; want_m = '{0, 0, 0, 0};
        check_rows("blank");
        one_frame("skel", 3, 5, 2);
        want_w = 5; want_s = '{3, 5, 7, 9}; want_e = '{7, 9, 11, 13}; want_m = '{5, 7, 9, 11};
        check_rows("skel");
        skel_cross("skel");

        // 6: wide flat run (holes allowed only inside it when noise is built in)
        one_frame("wide", 5, 10, 0);
        want_w = 10; want_s = '{5, 5, 5, 5}; want_e = '{14, 14, 14, 14}; want_m = '{10, 10, 10, 10};
        check_rows("wide");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
